// File: rtl/seven_segment_monitor_pkg.sv
// Shared seven-segment definitions: segment bit order, legal digit codes and monitor FSM states.
// Pure declarations; no logic, latency or backpressure.
package seven_segment_monitor_pkg;

  localparam int SEG_W           = 7;
  localparam int SEG_TOP         = 0;
  localparam int SEG_UPPER_RIGHT = 1;
  localparam int SEG_LOWER_RIGHT = 2;
  localparam int SEG_BOTTOM      = 3;
  localparam int SEG_LOWER_LEFT  = 4;
  localparam int SEG_UPPER_LEFT  = 5;
  localparam int SEG_MIDDLE      = 6;

  // Codes listed bit6 (middle) down to bit0 (top).
  localparam logic [SEG_W-1:0] SEG_CODE_0 = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_CODE_1 = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_CODE_2 = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_CODE_3 = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_CODE_4 = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_CODE_5 = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_CODE_6 = 7'b1111100;
  localparam logic [SEG_W-1:0] SEG_CODE_7 = 7'b0000111;
  localparam logic [SEG_W-1:0] SEG_CODE_8 = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_CODE_9 = 7'b1100111;

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    SYNCED     = 2'd1,
    MEASURING  = 2'd2
  } monitor_state_t;

endpackage

// File: rtl/seven_segment_monitor_pattern_decode.sv
// Combinational seven-segment pattern to digit decoder with a legal-code flag.
// Zero latency; no backpressure.
module seven_segment_pattern_decode
  import seven_segment_monitor_pkg::*;
(
  input  logic [SEG_W-1:0] pattern,
  output logic [3:0]       digit,
  output logic             legal
);

  always_comb begin
    digit = 4'd0;
    legal = 1'b1;
    case (pattern)
      SEG_CODE_0: digit = 4'd0;
      SEG_CODE_1: digit = 4'd1;
      SEG_CODE_2: digit = 4'd2;
      SEG_CODE_3: digit = 4'd3;
      SEG_CODE_4: digit = 4'd4;
      SEG_CODE_5: digit = 4'd5;
      SEG_CODE_6: digit = 4'd6;
      SEG_CODE_7: digit = 4'd7;
      SEG_CODE_8: digit = 4'd8;
      SEG_CODE_9: digit = 4'd9;
      default:    legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_segment_monitor.sv
// Watches a seven-segment encoder: debounces patterns, checks digit order and digit period.
// Pulses appear STABLE_CYCLES edges after a new pattern first samples; no backpressure.
module seven_segment_monitor
  import seven_segment_monitor_pkg::*;
#(
  parameter int MAX_COUNT     = 16_000_000,
  parameter int STABLE_CYCLES = 4,
  parameter int PERIOD_TOL    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SEG_W-1:0] segments_in,
  output logic [3:0]       digit_out,
  output logic             digit_valid,
  output logic             invalid_pattern,
  output logic             sequence_error,
  output logic [23:0]      period_out,
  output logic             period_error
);

  localparam int          CNT_W      = $clog2(STABLE_CYCLES + 1);
  localparam logic [24:0] EXP_PERIOD = 25'(MAX_COUNT + 1);
  localparam logic [24:0] TOL        = 25'(PERIOD_TOL);

  logic [SEG_W-1:0] sample_q;
  logic [SEG_W-1:0] last_pat;
  logic             last_vld;
  logic [CNT_W-1:0] stab_cnt;
  logic [23:0]      per_cnt;
  monitor_state_t   state;

  logic [3:0]  dec_digit;
  logic        dec_legal;
  logic        accept;
  logic [3:0]  next_digit;
  logic        seq_bad;
  logic [24:0] per_diff;
  logic        per_bad;

  seven_segment_pattern_decode u_decode (
    .pattern (sample_q),
    .digit   (dec_digit),
    .legal   (dec_legal)
  );

  // stab_cnt == STABLE_CYCLES-1 means the registered pattern has been seen on STABLE_CYCLES edges.
  assign accept     = (stab_cnt == CNT_W'(STABLE_CYCLES - 1)) && (!last_vld || (sample_q != last_pat));
  assign next_digit = (digit_out == 4'd9) ? 4'd0 : digit_out + 4'd1;
  assign seq_bad    = (dec_digit != next_digit);
  assign per_diff   = ({1'b0, per_cnt} >= EXP_PERIOD) ? ({1'b0, per_cnt} - EXP_PERIOD)
                                                      : (EXP_PERIOD - {1'b0, per_cnt});
  assign per_bad    = (per_cnt == 24'hFF_FFFF) || (per_diff > TOL);

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_q        <= '0;
      last_pat        <= '0;
      last_vld        <= 1'b0;
      stab_cnt        <= '0;
      per_cnt         <= '0;
      state           <= WAIT_FIRST;
      digit_out       <= 4'd0;
      period_out      <= 24'd0;
      digit_valid     <= 1'b0;
      invalid_pattern <= 1'b0;
      sequence_error  <= 1'b0;
      period_error    <= 1'b0;
    end else begin
      sample_q        <= segments_in;
      digit_valid     <= 1'b0;
      invalid_pattern <= 1'b0;
      sequence_error  <= 1'b0;
      period_error    <= 1'b0;

      if (segments_in != sample_q) begin
        stab_cnt <= '0;
      end else if (stab_cnt != CNT_W'(STABLE_CYCLES)) begin
        stab_cnt <= stab_cnt + 1'b1;
      end

      if (per_cnt != 24'hFF_FFFF) begin
        per_cnt <= per_cnt + 24'd1;
      end

      if (accept) begin
        last_pat <= sample_q;
        last_vld <= 1'b1;
        if (dec_legal) begin
          digit_valid <= 1'b1;
          digit_out   <= dec_digit;
          // Count 1 at the pulse edge so the stored value equals the edge spacing.
          per_cnt     <= 24'd1;
          case (state)
            WAIT_FIRST: state <= SYNCED;
            SYNCED: begin
              period_out <= per_cnt;
              if (seq_bad) begin
                sequence_error <= 1'b1;
              end else begin
                state <= MEASURING;
              end
            end
            default: begin
              period_out     <= per_cnt;
              sequence_error <= seq_bad;
              period_error   <= per_bad;
            end
          endcase
        end else begin
          invalid_pattern <= 1'b1;
          per_cnt         <= 24'd0;
          state           <= WAIT_FIRST;
        end
      end
    end
  end

endmodule
